uart_frame_parser: RTL and testbench

//  Consumes the byte stream from the UART receiver (byte_in + one-cycle byte_valid strobe) and assembles framed commands.

---
 rtl/uart_frame_parser_if.sv | 33 +++
 rtl/uart_frame_parser.sv | 156 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_if.sv
// Byte-stream, status and payload read-port bundle for uart_frame_parser.
// The slave modport is the parser's view; the master modport is the UART/consumer side.
interface uart_frame_parser_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              frame_valid;
    logic [ADDR_W:0]   frame_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_ack;
    logic              err_chk;
    logic              err_len;
    logic              err_ovr;
    logic              err_tmo;
    logic [2:0]        state_dbg;

    // byte_valid is a one-cycle strobe with no back-pressure: a byte is taken
    // on every cycle it is high. frame_valid is held until the cycle after
    // frame_ack; frame_ack has no effect while frame_valid is low.
    modport slave (
        input  byte_in, byte_valid, rd_addr, frame_ack,
        output frame_valid, frame_len, rd_data,
        output err_chk, err_len, err_ovr, err_tmo, state_dbg
    );

    modport master (
        output byte_in, byte_valid, rd_addr, frame_ack,
        input  frame_valid, frame_len, rd_data,
        input  err_chk, err_len, err_ovr, err_tmo, state_dbg
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/LEN/payload/CHK frames from a UART byte stream into a readable buffer.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hAA,
    parameter int         MAX_LEN      = 16,
    parameter int         ADDR_W       = 4,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input logic                clk,
    input logic                rst_n,
    uart_frame_parser_if.slave bus
);
    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic [7:0]        acc_q, acc_d;
    logic              frame_valid_q, frame_valid_d;
    logic              err_chk_q, err_chk_d;
    logic              err_len_q, err_len_d;
    logic              err_ovr_q, err_ovr_d;
    logic              err_tmo_q;
    logic              wr_en;
    logic              tmo_hit;
    logic [7:0]        mem_q [2**ADDR_W];

`ifdef FRAME_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts idle cycles only while a frame is partially received.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((state_q inside {S_LEN, S_PAYLOAD, S_CHK}) && !bus.byte_valid) begin
            if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) tmo_hit = 1'b1;
            else                                   tmo_d   = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    // No timeout hardware; the expression is constant 0 and keeps the parameter referenced.
    assign tmo_hit = (TIMEOUT_CLKS < 0);
`endif

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        frame_valid_d = frame_valid_q;
        frame_len_d   = frame_len_q;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_ovr_d     = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            S_HUNT: begin
                if (bus.byte_valid && bus.byte_in == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (bus.byte_valid) begin
                    if (bus.byte_in != 8'd0 && bus.byte_in <= MAX_LEN_B) begin
                        len_d   = (ADDR_W+1)'(bus.byte_in);
                        acc_d   = bus.byte_in;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.byte_valid) begin
                    wr_en = 1'b1;
                    acc_d = acc_q + bus.byte_in;
                    idx_d = idx_q + ONE;
                    if (idx_q == len_q - ONE) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (bus.byte_valid) begin
                    if (bus.byte_in == acc_q) begin
                        frame_valid_d = 1'b1;
                        frame_len_d   = len_q;
                        state_d       = S_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                // Incoming bytes are dropped; the held buffer is never touched here.
                if (bus.byte_valid) err_ovr_d = 1'b1;
                if (bus.frame_ack) begin
                    frame_valid_d = 1'b0;
                    frame_len_d   = '0;
                    state_d       = S_HUNT;
                end
            end
            default: state_d = S_HUNT;
        endcase
        if (tmo_hit) state_d = S_HUNT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_ovr_q     <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_ovr_q     <= err_ovr_d;
            err_tmo_q     <= tmo_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q[ADDR_W-1:0]] <= bus.byte_in;
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.rd_data     = (frame_valid_q && ({1'b0, bus.rd_addr} < frame_len_q))
                             ? mem_q[bus.rd_addr] : 8'h00;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_ovr     = err_ovr_q;
    assign bus.err_tmo     = err_tmo_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: vector table, corner-case sequences,
// and randomized byte streams scored against a queue-based frame model.
module tb_uart_frame_parser;
    localparam logic [7:0] SYNC    = 8'hAA;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 8680;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_frame_parser_if #(.ADDR_W(4)) bus ();

    uart_frame_parser #(
        .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .ADDR_W(4), .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_ack  = 1'b0;
        bus.rd_addr    = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic drive_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.frame_valid, bus.err_chk, bus.err_len, bus.err_ovr, bus.err_tmo};
    endfunction

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        #1;
        check(name, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         n;
        logic [7:0] b [20];
        logic [4:0] fl;      // {frame_valid, chk, len, ovr, tmo} after the last byte
        int         len;
        logic [7:0] d0;
    } vec_t;

    vec_t vecs [10];
    int   n_vecs = 0;

    task automatic add_vec(input string nm, input logic [7:0] bq[$], input logic [4:0] fl,
                           input int ln, input logic [7:0] d0);
        vecs[n_vecs].name = nm;
        vecs[n_vecs].n    = bq.size();
        for (int j = 0; j < 20; j++) vecs[n_vecs].b[j] = (j < bq.size()) ? bq[j] : 8'h00;
        vecs[n_vecs].fl   = fl;
        vecs[n_vecs].len  = ln;
        vecs[n_vecs].d0   = d0;
        n_vecs++;
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [4:0] exp_q [$];
    logic [7:0] col [$];     // bytes of the frame being collected, SYNC first
    logic [7:0] m_buf [$];   // payload of the held frame
    bit         m_hold;

    task automatic step(input bit v, input logic [7:0] b, input bit ack);
        int         ev;
        int         sum;
        int         ln;
        logic [3:0] a;
        logic [4:0] exp_fl;
        logic [7:0] exp_rd;
        ev = 0;
        if (m_hold) begin
            if (v) ev = 3;
            if (ack) m_hold = 0;
        end else if (v) begin
            if (col.size() == 0) begin
                if (b == SYNC) col.push_back(b);
            end else if (col.size() == 1) begin
                if (int'(b) >= 1 && int'(b) <= MAX_LEN) col.push_back(b);
                else begin ev = 2; col.delete(); end
            end else begin
                col.push_back(b);
                ln = int'(col[1]);
                if (col.size() == ln + 3) begin
                    sum = 0;
                    for (int i = 1; i <= ln + 1; i++) sum += int'(col[i]);
                    if ((sum % 256) == int'(b)) begin
                        m_hold = 1;
                        m_buf.delete();
                        for (int i = 2; i < ln + 2; i++) m_buf.push_back(col[i]);
                    end else begin
                        ev = 1;
                    end
                    col.delete();
                end
            end
        end
        exp_q.push_back({m_hold, ev == 1, ev == 2, ev == 3, 1'b0});

        bus.byte_in    = b;
        bus.byte_valid = v;
        bus.frame_ack  = ack;
        tick();
        bus.byte_valid = 1'b0;
        bus.frame_ack  = 1'b0;

        exp_fl = exp_q.pop_front();
        check("rand_flags", {27'd0, flags()}, {27'd0, exp_fl});
        a = 4'($urandom_range(0, 15));
        exp_rd = (m_hold && int'(a) < m_buf.size()) ? m_buf[a] : 8'h00;
        read_check("rand_rd_data", a, exp_rd);
        if (m_hold) check("rand_frame_len", {27'd0, bus.frame_len}, m_buf.size());
    endtask

    task automatic play(input logic [7:0] q[$]);
        for (int i = 0; i < q.size(); i++) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, m_hold && ($urandom_range(0, 3) == 0));
            step(1'b1, q[i], m_hold && ($urandom_range(0, 3) == 0));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] tq [$];
        int         cnt;
        int         first_k;
        int         ln;
        int         sum;

        // reset state, checked while reset is asserted
        rst_n          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.frame_ack  = 1'b0;
        bus.rd_addr    = '0;
        #12;
        check("reset_flags", {27'd0, flags()}, 0);
        check("reset_frame_len", {27'd0, bus.frame_len}, 0);
        check("reset_rd_data", {24'd0, bus.rd_data}, 0);
        do_reset();

        // table
        tq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; add_vec("good3", tq, 5'b10000, 3, 8'h11);
        tq = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h31};        add_vec("badchk", tq, 5'b01000, 0, 8'h00);
        tq = '{8'hAA, 8'h01, 8'h05, 8'h06};               add_vec("good1", tq, 5'b10000, 1, 8'h05);
        tq = '{8'hAA, 8'h00};                             add_vec("len0", tq, 5'b00100, 0, 8'h00);
        tq = '{8'hAA, 8'h11};                             add_vec("len17", tq, 5'b00100, 0, 8'h00);
        tq = '{8'hFF, 8'hAA, 8'h01, 8'h02, 8'h03};        add_vec("noise_then_sync", tq, 5'b10000, 1, 8'h02);
        tq = '{8'hAA, 8'hAA};                             add_vec("len_is_sync", tq, 5'b00100, 0, 8'h00);
        tq.delete();
        tq.push_back(8'hAA); tq.push_back(8'h10);
        for (int j = 0; j < 16; j++) tq.push_back(8'(j + 3));
        sum = 16;
        for (int j = 0; j < 16; j++) sum += j + 3;
        tq.push_back(8'(sum));
        add_vec("maxlen", tq, 5'b10000, 16, 8'h03);

        for (int i = 0; i < n_vecs; i++) begin
            for (int j = 0; j < vecs[i].n; j++) drive_byte(vecs[i].b[j]);
            check({vecs[i].name, "_flags"}, {27'd0, flags()}, {27'd0, vecs[i].fl});
            tick();
            check({vecs[i].name, "_pulse_end"}, {27'd0, flags()}, {27'd0, vecs[i].fl & 5'b10000});
            if (vecs[i].fl[4]) begin
                check({vecs[i].name, "_len"}, {27'd0, bus.frame_len}, vecs[i].len);
                read_check({vecs[i].name, "_rd0"}, 4'd0, vecs[i].d0);
                if (vecs[i].len < 16) read_check({vecs[i].name, "_rd_oob"}, 4'(vecs[i].len), 8'h00);
                pulse_ack();
                check({vecs[i].name, "_ack"}, {31'd0, bus.frame_valid}, 0);
                read_check({vecs[i].name, "_rd_after_ack"}, 4'd0, 8'h00);
            end
        end

        // good3 data readback
        drive_byte(8'hAA); drive_byte(8'h03); drive_byte(8'h11); drive_byte(8'h22);
        drive_byte(8'h33); drive_byte(8'h69);
        read_check("good3_rd1", 4'd1, 8'h22);
        read_check("good3_rd2", 4'd2, 8'h33);
        pulse_ack();

        // overrun while holding, including a byte in the ack cycle
        drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h05); drive_byte(8'h06);
        drive_byte(8'h55);
        check("ovr1_flags", {27'd0, flags()}, 5'b10010);
        read_check("ovr1_rd0", 4'd0, 8'h05);
        tick();
        check("ovr1_pulse_end", {27'd0, flags()}, 5'b10000);
        bus.byte_in = 8'h77; bus.byte_valid = 1'b1; bus.frame_ack = 1'b1;
        tick();
        bus.byte_valid = 1'b0; bus.frame_ack = 1'b0;
        check("ovr2_ack_flags", {27'd0, flags()}, 5'b00010);
        tick();
        check("ovr2_pulse_end", {27'd0, flags()}, 0);
        drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h07); drive_byte(8'h08);
        check("after_ovr_flags", {27'd0, flags()}, 5'b10000);
        read_check("after_ovr_rd0", 4'd0, 8'h07);
        pulse_ack();

        // frame_ack outside HOLD is ignored
        pulse_ack();
        check("ack_idle_flags", {27'd0, flags()}, 0);
        drive_byte(8'hAA); drive_byte(8'h02); drive_byte(8'h10);
        pulse_ack();
        drive_byte(8'h20); drive_byte(8'h32);
        check("ack_midframe_flags", {27'd0, flags()}, 5'b10000);
        check("ack_midframe_len", {27'd0, bus.frame_len}, 2);
        pulse_ack();

        // inter-byte timeout
        drive_byte(8'hAA); drive_byte(8'h02); drive_byte(8'h10);
        cnt = 0; first_k = -1;
        for (int k = 1; k <= TMO + 10; k++) begin
            tick();
            if (bus.err_tmo) begin
                cnt++;
                if (first_k < 0) first_k = k;
            end
        end
        drive_byte(8'h20); drive_byte(8'h32);
`ifdef FRAME_TIMEOUT_EN
        check("tmo_pulse_count", cnt, 1);
        check("tmo_pulse_near_limit", (first_k >= TMO - 1 && first_k <= TMO + 1), 1);
        check("tmo_late_bytes_ignored", {27'd0, flags()}, 0);
`else
        check("no_tmo_pulse", cnt, 0);
        check("late_frame_flags", {27'd0, flags()}, 5'b10000);
        check("late_frame_len", {27'd0, bus.frame_len}, 2);
        read_check("late_frame_rd0", 4'd0, 8'h10);
        read_check("late_frame_rd1", 4'd1, 8'h20);
        pulse_ack();
`endif

        // asynchronous reset while holding, then mid-payload
        drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h05); drive_byte(8'h06);
        check("pre_reset_hold", {31'd0, bus.frame_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags", {27'd0, flags()}, 0);
        check("async_reset_len", {27'd0, bus.frame_len}, 0);
        check("async_reset_rd", {24'd0, bus.rd_data}, 0);
        #3 rst_n = 1'b1;
        tick();
        drive_byte(8'hAA); drive_byte(8'h03); drive_byte(8'h11);
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        drive_byte(8'hAA); drive_byte(8'h01); drive_byte(8'h07); drive_byte(8'h08);
        check("post_reset_flags", {27'd0, flags()}, 5'b10000);
        check("post_reset_len", {27'd0, bus.frame_len}, 1);
        read_check("post_reset_rd0", 4'd0, 8'h07);

        // randomized streams against the model
        do_reset();
        col.delete(); m_buf.delete(); m_hold = 0;
        for (int it = 0; it < 60; it++) begin
            tq.delete();
            case ($urandom_range(0, 4))
                0, 1: begin
                    ln = $urandom_range(1, MAX_LEN);
                    tq.push_back(SYNC); tq.push_back(8'(ln));
                    sum = ln;
                    for (int j = 0; j < ln; j++) begin
                        tq.push_back(8'($urandom_range(0, 255)));
                        sum += int'(tq[tq.size()-1]);
                    end
                    tq.push_back(8'(sum));
                end
                2: begin
                    ln = $urandom_range(1, MAX_LEN);
                    tq.push_back(SYNC); tq.push_back(8'(ln));
                    sum = ln;
                    for (int j = 0; j < ln; j++) begin
                        tq.push_back(8'($urandom_range(0, 255)));
                        sum += int'(tq[tq.size()-1]);
                    end
                    tq.push_back(8'(sum + $urandom_range(1, 255)));
                end
                3: begin
                    tq.push_back(SYNC);
                    tq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
                end
                default: begin
                    repeat ($urandom_range(1, 3)) tq.push_back(8'($urandom_range(0, 255)));
                end
            endcase
            play(tq);
            if ($urandom_range(0, 1) == 0) step(1'b0, 8'h00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
